fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 16-bit pipelined core, sitting directly upstream of the decode stage. Owns the program counter and drives the instruction-memory read address. Assembles one- or two-word instructions, where the second word is an immediate. Delivers the assembled instruction, immediate and next-PC to decode through the IF/ID pipeline register. Supports boot-vector load, hazard stall and branch redirect.

## Interface
- `PC_W`, default 20: program counter and instruction-address width.
- `IMM_BIT`, default 15: instruction bit that flags a following immediate word.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: from the hazard unit; holds PC, state and IF/ID.
- `branch_taken` in 1: redirect request from a later stage; also flushes fetch.
- `branch_target` in PC_W: redirect address, valid when `branch_taken`=1.
- `imem_addr` out PC_W: combinational instruction-memory address.
- `imem_data` in 16: instruction-memory read data, valid in the same cycle (asynchronous read).
- `instr_out` out 16: IF/ID instruction word.
  - Opcode is [15:9], Rsrc1 [8:6], Rsrc2 [5:3], Rdst [2:0].
- `imm_out` out 16: IF/ID immediate; 0 for single-word instructions.
- `pc_out` out PC_W: IF/ID address of the next sequential instruction.
- `valid_out` out 1: IF/ID holds a real instruction (0 = bubble).

## Operation
- States are BOOT, FETCH_OP and FETCH_IMM. Registers are `pc`, `state`, `op_hold` (16) and the IF/ID fields.
- `imem_addr` is 0 in BOOT and `pc` in the other states.
- Priority per cycle: `rst` > `branch_taken` > `stall` > normal progress.
- **BOOT:**
  - `pc` <= zero-extended `imem_data`, which is M[0], the reset vector.
  - Next state is FETCH_OP. IF/ID loads a bubble.
  - `stall` and `branch_taken` are ignored in this state.
- **FETCH_OP, normal progress:**
  - `pc` <= `pc`+1.
  - If `imem_data[IMM_BIT]`=0:
    - IF/ID <= {`imem_data`, imm 0, `pc`+1, valid 1}.
    - Stay in FETCH_OP.
  - Else:
    - `op_hold` <= `imem_data`.
    - IF/ID <= bubble.
    - Next state is FETCH_IMM.
- **FETCH_IMM, normal progress:**
  - `pc` <= `pc`+1.
  - IF/ID <= {`op_hold`, `imem_data`, `pc`+1, valid 1}.
  - Next state is FETCH_OP.
- **Bubble encoding:** `instr_out`=16'h0000 (NOP), `imm_out`=0, `pc_out` holds its previous value, `valid_out`=0.
- **`stall`=1 (not in BOOT):** `pc`, `state`, `op_hold` and all IF/ID fields hold.
- **`branch_taken`=1 (not in BOOT):**
  - `pc` <= `branch_target` and state <= FETCH_OP.
  - IF/ID <= bubble.
  - Any half-fetched two-word instruction in `op_hold` is discarded.
  - Branch wins over a simultaneous `stall`.
- **Wrap-around:** `pc` increments modulo 2^PC_W; `pc_out` wraps identically.
- **Reset values:**
  - State is BOOT; `pc`=0; `op_hold`=0.
  - `instr_out`=0, `imm_out`=0, `pc_out`=0, `valid_out`=0.
- **Reset mid-operation:** a pending two-word fetch is dropped and the boot sequence restarts.

## Timing
- Single-word instruction:
  - Address presented in cycle N.
  - `instr_out`/`valid_out` visible after the edge ending cycle N, i.e. 1-cycle latency.
- Two-word instruction:
  - Opcode word addressed in cycle N, immediate in N+1.
  - IF/ID valid after edge N+1, with exactly one bubble cycle emitted first.
- Boot:
  - Reset deasserts; BOOT occupies one cycle.
  - First `imem_addr`=vector in the following cycle.
  - First valid IF/ID two cycles after reset release.
- Redirect: the `branch_target` instruction is addressed in the cycle after `branch_taken` and reaches IF/ID one cycle later.
- `imem_addr` is combinational from registered state only. There is no combinational path from `stall` or `branch_taken` to `imem_addr`.

## Structure
- Shared package `fetch_pkg`:
  - State enum `fetch_state_t` (BOOT, FETCH_OP, FETCH_IMM).
  - Constant `NOP_INSTR`=16'h0000.
  - Opcode/register field position constants, shared with decode.
- One sub-module, `if_id_reg`:
  - Holds `instr`/`imm`/`pc`/`valid`.
  - Has `stall` (hold) and `bubble` (load NOP, valid 0) controls.
  - Reused for the IF/ID boundary only.
- PC, state machine and `op_hold` live in `fetch_stage`.

## Test plan
- **Boot:** M[0]=16'h0010, M[0x10]=16'h1A53; release `rst`. Expected: `imem_addr`=0, then 0x10; IF/ID `instr_out`=16'h1A53, `pc_out`=0x11, `valid_out`=1 two cycles after release.
- **Two-word instruction:** M[0x10]=16'h8000 (IMM_BIT set), M[0x11]=16'hBEEF. Expected: one bubble, then `instr_out`=16'h8000, `imm_out`=16'hBEEF, `pc_out`=0x12; next `imem_addr`=0x12.
- **Stall:** stall held 3 cycles mid-stream. Expected: `imem_addr`, `instr_out` and `pc_out` unchanged for 3 cycles; the sequence resumes with no skipped or duplicated instruction.
- **Branch mid-immediate:** `branch_taken`=1 with `branch_target`=0x40 in FETCH_IMM. Expected: next `imem_addr`=0x40, IF/ID bubble, opcode word never emitted.
- **Branch+stall same cycle:** `branch_taken`=1 with `stall`=1. Expected: redirect takes effect (`imem_addr`=target next cycle).
- **Wrap:** `pc`=2^PC_W−1 holding a single-word instruction. Expected: `pc_out`=0 and next `imem_addr`=0.
- **Reset during FETCH_IMM:** assert `rst` in FETCH_IMM. Expected: all outputs 0 next cycle, state BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    FETCH_OP  = 2'd1,
    FETCH_IMM = 2'd2
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Instruction word field positions, shared with decode.
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 9;
  localparam int RSRC1_HI  = 8;
  localparam int RSRC1_LO  = 6;
  localparam int RSRC2_HI  = 5;
  localparam int RSRC2_LO  = 3;
  localparam int RDST_HI   = 2;
  localparam int RDST_LO   = 0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds instruction, immediate, next-PC and valid.
// bubble loads a NOP with valid 0 and keeps the previous pc; stall holds all.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int PC_W = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            bubble,
  input  logic [15:0]     instr_d,
  input  logic [15:0]     imm_d,
  input  logic [PC_W-1:0] pc_d,
  output logic [15:0]     instr,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic            valid
);

  // Register update: reset, then bubble (wins over stall), then hold, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= NOP_INSTR;
      imm   <= 16'h0000;
      pc    <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      imm   <= 16'h0000;
      valid <= 1'b0;
    end else if (!stall) begin
      instr <= instr_d;
      imm   <= imm_d;
      pc    <= pc_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, assembles one- or two-word
// instructions and hands them to decode through the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int PC_W    = 20,
  parameter int IMM_BIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr_out,
  output logic [15:0]     imm_out,
  output logic [PC_W-1:0] pc_out,
  output logic            valid_out
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     op_hold, op_hold_nxt;

  logic            hold_p0;
  logic            bubble_p0;
  logic [15:0]     instr_p0;
  logic [15:0]     imm_p0;
  logic [PC_W-1:0] pc_p0;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc + PC_W'(1);

  // Address depends only on registered state: the reset vector lives at 0.
  assign imem_addr = (state == BOOT) ? '0 : pc;

  // Next-state, next-PC and IF/ID load controls; priority branch > stall > progress.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    op_hold_nxt = op_hold;
    hold_p0     = 1'b0;
    bubble_p0   = 1'b0;
    instr_p0    = imem_data;
    imm_p0      = 16'h0000;
    pc_p0       = pc_inc;
    case (state)
      BOOT: begin
        pc_nxt    = PC_W'(imem_data);
        state_nxt = FETCH_OP;
        bubble_p0 = 1'b1;
      end
      FETCH_OP: begin
        if (branch_taken) begin
          pc_nxt    = branch_target;
          state_nxt = FETCH_OP;
          bubble_p0 = 1'b1;
        end else if (stall) begin
          hold_p0 = 1'b1;
        end else begin
          pc_nxt = pc_inc;
          if (imem_data[IMM_BIT]) begin
            op_hold_nxt = imem_data;
            bubble_p0   = 1'b1;
            state_nxt   = FETCH_IMM;
          end
        end
      end
      FETCH_IMM: begin
        if (branch_taken) begin
          pc_nxt      = branch_target;
          state_nxt   = FETCH_OP;
          op_hold_nxt = 16'h0000;
          bubble_p0   = 1'b1;
        end else if (stall) begin
          hold_p0 = 1'b1;
        end else begin
          pc_nxt    = pc_inc;
          instr_p0  = op_hold;
          imm_p0    = imem_data;
          state_nxt = FETCH_OP;
        end
      end
      default: begin
        state_nxt = BOOT;
        bubble_p0 = 1'b1;
      end
    endcase
  end

  // PC, state and opcode holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      pc      <= '0;
      op_hold <= 16'h0000;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      op_hold <= op_hold_nxt;
    end
  end

  // ---- IF/ID boundary: p0 fetch values registered into the decode-facing stage ----
  if_id_reg #(.PC_W(PC_W)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .stall   (hold_p0),
    .bubble  (bubble_p0),
    .instr_d (instr_p0),
    .imm_d   (imm_p0),
    .pc_d    (pc_p0),
    .instr   (instr_out),
    .imm     (imm_out),
    .pc      (pc_out),
    .valid   (valid_out)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an asynchronous-read instruction memory.
module tb_fetch_stage;

  localparam int PC_W = 20;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic [15:0]     instr_out;
  logic [15:0]     imm_out;
  logic [PC_W-1:0] pc_out;
  logic            valid_out;

  logic [15:0] mem [0:(1<<PC_W)-1];

  int tests = 0;
  int fails = 0;

  fetch_stage #(.PC_W(PC_W), .IMM_BIT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr_out     (instr_out),
    .imm_out       (imm_out),
    .pc_out        (pc_out),
    .valid_out     (valid_out)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                          input logic [PC_W-1:0] pcv, input logic vld,
                          input logic [PC_W-1:0] addr);
    chk({tag, ".instr"}, 32'(instr_out), 32'(ins));
    chk({tag, ".imm"},   32'(imm_out),   32'(imm));
    chk({tag, ".pc"},    32'(pc_out),    32'(pcv));
    chk({tag, ".valid"}, 32'(valid_out), 32'(vld));
    chk({tag, ".addr"},  32'(imem_addr), 32'(addr));
  endtask

  initial begin
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = 16'h0000;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // Boot and single-word stream
    mem[0]    = 16'h0010;
    mem[20'h10] = 16'h1A53;
    mem[20'h11] = 16'h0101;
    mem[20'h12] = 16'h0202;
    mem[20'h13] = 16'h0303;
    step(); step();
    chk_ifid("reset", 16'h0000, 16'h0000, 20'h0, 1'b0, 20'h0);
    rst = 1'b0;
    #1;
    chk("boot.addr0", 32'(imem_addr), 32'h0);
    step();
    chk_ifid("boot.bubble", 16'h0000, 16'h0000, 20'h0, 1'b0, 20'h10);
    step();
    chk_ifid("boot.first", 16'h1A53, 16'h0000, 20'h11, 1'b1, 20'h11);
    step();
    chk_ifid("seq.0101", 16'h0101, 16'h0000, 20'h12, 1'b1, 20'h12);

    // Stall held three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid("stall.hold", 16'h0101, 16'h0000, 20'h12, 1'b1, 20'h12);
    end
    stall = 1'b0;
    step();
    chk_ifid("stall.resume", 16'h0202, 16'h0000, 20'h13, 1'b1, 20'h13);
    step();
    chk_ifid("stall.next", 16'h0303, 16'h0000, 20'h14, 1'b1, 20'h14);

    // Two-word instruction after a fresh boot
    rst = 1'b1;
    mem[20'h10] = 16'h8000;
    mem[20'h11] = 16'hBEEF;
    mem[20'h12] = 16'h8123;
    mem[20'h13] = 16'h7777;
    mem[20'h40] = 16'h0444;
    mem[20'h41] = 16'h0555;
    mem[20'h60] = 16'h0666;
    mem[20'hFFFFF] = 16'h0777;
    step();
    chk_ifid("reset2", 16'h0000, 16'h0000, 20'h0, 1'b0, 20'h0);
    rst = 1'b0;
    step();
    chk_ifid("tw.boot", 16'h0000, 16'h0000, 20'h0, 1'b0, 20'h10);
    step();
    chk_ifid("tw.bubble", 16'h0000, 16'h0000, 20'h0, 1'b0, 20'h11);
    step();
    chk_ifid("tw.emit", 16'h8000, 16'hBEEF, 20'h12, 1'b1, 20'h12);

    // Branch while waiting for an immediate word
    step();
    chk_ifid("br.opword", 16'h0000, 16'h0000, 20'h12, 1'b0, 20'h13);
    branch_taken = 1'b1; branch_target = 20'h40;
    step();
    chk_ifid("br.redirect", 16'h0000, 16'h0000, 20'h12, 1'b0, 20'h40);
    branch_taken = 1'b0;
    step();
    chk_ifid("br.target", 16'h0444, 16'h0000, 20'h41, 1'b1, 20'h41);

    // Branch and stall in the same cycle
    branch_taken = 1'b1; stall = 1'b1; branch_target = 20'h60;
    step();
    chk_ifid("brstall.redirect", 16'h0000, 16'h0000, 20'h41, 1'b0, 20'h60);
    branch_taken = 1'b0; stall = 1'b0;
    step();
    chk_ifid("brstall.target", 16'h0666, 16'h0000, 20'h61, 1'b1, 20'h61);

    // PC wrap-around at the top of the address space
    branch_taken = 1'b1; branch_target = 20'hFFFFF;
    step();
    chk("wrap.addr_top", 32'(imem_addr), 32'hFFFFF);
    branch_taken = 1'b0;
    step();
    chk_ifid("wrap", 16'h0777, 16'h0000, 20'h0, 1'b1, 20'h0);

    // Reset while an immediate word is pending
    mem[20'h50] = 16'h8ABC;
    mem[20'h51] = 16'h1234;
    branch_taken = 1'b1; branch_target = 20'h50;
    step();
    branch_taken = 1'b0;
    step();
    chk_ifid("rstimm.pending", 16'h0000, 16'h0000, 20'h0, 1'b0, 20'h51);
    rst = 1'b1;
    step();
    chk_ifid("rstimm.reset", 16'h0000, 16'h0000, 20'h0, 1'b0, 20'h0);
    rst = 1'b0;
    step();
    chk_ifid("rstimm.reboot", 16'h0000, 16'h0000, 20'h0, 1'b0, 20'h10);
    step();
    chk_ifid("rstimm.bubble", 16'h0000, 16'h0000, 20'h0, 1'b0, 20'h11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
